// File: rtl/keypad_scanner_param.sv
// keypad_scanner_param
// Matrix-keypad scanner with an integrated press/release debouncer.
// It strobes the rows one at a time and samples the active-low columns
// through a 2-FF synchroniser. A stable single-key press produces a
// one-cycle key_valid pulse and updates key_code. A stable press of two or
// more keys in one row produces a one-cycle multi_press pulse instead.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous reset, active-low
//   cols        in   [NUM_COLS]  raw column inputs, active-low, asynchronous
//   rows        out  [NUM_ROWS]  one-hot row strobes, active-high
//   key_code    out  [CODE_W]    last accepted key, row_idx*NUM_COLS + col_idx
//   key_valid   out  one-cycle pulse on each accepted single-key press
//   key_held    out  high while an accepted press (single or multi) is held
//   multi_press out  one-cycle pulse on an accepted multi-key press
module keypad_scanner_param #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SCAN_DIV        = 1024,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CODE_W          = $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] cols,
  output logic [NUM_ROWS-1:0] rows,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_press
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int CW = $clog2(NUM_COLS);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [NUM_ROWS-1:0] ROWS_RST = {1'b1, {(NUM_ROWS-1){1'b0}}};

  // Row index r is strobed on rows[NUM_ROWS-1-r].
  function automatic logic [RW-1:0] row_index(input logic [NUM_ROWS-1:0] oh);
    row_index = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (oh[i]) row_index = RW'(NUM_ROWS - 1 - i);
    end
  endfunction

  // Column index c is read on cols[NUM_COLS-1-c]; used only when one bit is low.
  function automatic logic [CW-1:0] col_index(input logic [NUM_COLS-1:0] pat);
    col_index = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!pat[i]) col_index = CW'(NUM_COLS - 1 - i);
    end
  endfunction

  function automatic logic [3:0] count_low(input logic [NUM_COLS-1:0] pat);
    count_low = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!pat[i]) count_low = count_low + 4'd1;
    end
  endfunction

  logic [1:0]          state_q, state_d;
  logic [NUM_COLS-1:0] cs1_q, cs1_d;
  logic [NUM_COLS-1:0] cs_q, cs_d;
  logic [NUM_ROWS-1:0] rows_q, rows_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [BW-1:0]       deb_q, deb_d;
  logic [RW-1:0]       row_idx_q, row_idx_d;
  logic [NUM_COLS-1:0] pat_q, pat_d;
  logic [CODE_W-1:0]   key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;
  logic                multi_q, multi_d;
  logic [NUM_ROWS-1:0] rows_next;

  always_comb begin
    state_d     = state_q;
    cs1_d       = cols;
    cs_d        = cs1_q;
    rows_d      = rows_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    row_idx_d   = row_idx_q;
    pat_d       = pat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_d     = 1'b0;
    // Rotate right: LSB wraps back to MSB.
    rows_next   = {rows_q[0], rows_q[NUM_ROWS-1:1]};

    case (state_q)
      ST_SCAN: begin
        // dwell_q restarts at 0 on every row change, so its first two
        // counts cover the synchroniser latency after the strobe moves.
        if (dwell_q >= DW'(2) && cs_q != '1) begin
          state_d   = ST_DEBOUNCE;
          row_idx_d = row_index(rows_q);
          pat_d     = cs_q;
          deb_d     = '0;
        end else if (dwell_q == DW'(SCAN_DIV - 1)) begin
          rows_d  = rows_next;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (cs_q != pat_q) begin
          state_d = ST_SCAN;
          rows_d  = rows_next;
          dwell_d = '0;
        end else if (deb_q == BW'(DEBOUNCE_CYCLES - 1)) begin
          state_d    = ST_HELD;
          key_held_d = 1'b1;
          if (count_low(pat_q) == 4'd1) begin
            key_valid_d = 1'b1;
            key_code_d  = CODE_W'(int'(row_idx_q) * NUM_COLS + int'(col_index(pat_q)));
          end else begin
            multi_d = 1'b1;
          end
        end else begin
          deb_d = deb_q + BW'(1);
        end
      end
      ST_HELD: begin
        if (cs_q == '1) begin
          state_d = ST_RELEASE;
          deb_d   = '0;
        end
      end
      default: begin
        // Release: any low column is treated as a glitch and re-holds.
        if (cs_q != '1) begin
          state_d = ST_HELD;
        end else if (deb_q == BW'(DEBOUNCE_CYCLES - 1)) begin
          state_d    = ST_SCAN;
          key_held_d = 1'b0;
          rows_d     = rows_next;
          dwell_d    = '0;
        end else begin
          deb_d = deb_q + BW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_SCAN;
      cs1_q       <= '1;
      cs_q        <= '1;
      rows_q      <= ROWS_RST;
      dwell_q     <= '0;
      deb_q       <= '0;
      row_idx_q   <= '0;
      pat_q       <= '1;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs1_q       <= cs1_d;
      cs_q        <= cs_d;
      rows_q      <= rows_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      row_idx_q   <= row_idx_d;
      pat_q       <= pat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_q     <= multi_d;
    end
  end

  assign rows        = rows_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign multi_press = multi_q;

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Testbench for keypad_scanner_param (4x4, SCAN_DIV=8, DEBOUNCE_CYCLES=16).
// Columns come either from a direct drive or from a simple keypad model
// that pulls a column low only while the row of a pressed key is strobed.
module tb_keypad_scanner_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_press;

  logic       use_model = 1'b0;
  logic [3:0] cols_drv = 4'b1111;
  logic [15:0] keys = '0;   // keys[r*4+c] = key at row r, column c pressed

  int n_cmp = 0;
  int n_fail = 0;
  int kv_cnt = 0;
  int mp_cnt = 0;
  int both_cnt = 0;

  keypad_scanner_param #(
    .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(8), .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows),
    .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held), .multi_press(multi_press)
  );

  always #5 clk = ~clk;

  always_comb begin
    cols = cols_drv;
    if (use_model) begin
      cols = 4'b1111;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (rows[3-r] && keys[r*4+c]) cols[3-c] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (multi_press === 1'b1) mp_cnt++;
    if (key_valid === 1'b1 && multi_press === 1'b1) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows;
    reset = 1'b0;
    cols_drv = 4'b1111;
    repeat (3) tick();
    n_cmp++; if (rows !== 4'b1000) begin n_fail++; $display("FAIL reset_rows got %b want 1000", rows); end
    n_cmp++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", key_code); end
    n_cmp++; if ({key_valid, key_held, multi_press} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {key_valid, key_held, multi_press}); end
    reset = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      exp_rows = 4'b1000 >> ((e / 8) % 4);
      if (e == 32) exp_rows = 4'b1000;
      n_cmp++; if (rows !== exp_rows) begin
        n_fail++; $display("FAIL scan_rows edge %0d got %b want %b", e, rows, exp_rows); end
    end
  endtask

  task automatic test_single_key();
    bit got = 0;
    int pulses = 0;
    int at = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (rows === 4'b0010) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL wait_row2 got %b want 0010", rows); end
    cols_drv = 4'b1110;   // set just after the row change edge
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (key_valid === 1'b1) begin pulses++; at = k; end
    end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulses got %0d want 1", pulses); end
    n_cmp++; if (at != 19) begin n_fail++; $display("FAIL single_latency got %0d want 19", at); end
    n_cmp++; if (key_code !== 4'd11) begin n_fail++; $display("FAIL single_code got %0d want 11", key_code); end
    n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL single_held got %b want 1", key_held); end
    n_cmp++; if (rows !== 4'b0010) begin n_fail++; $display("FAIL single_frozen got %b want 0010", rows); end
    cols_drv = 4'b1111;
    repeat (10) tick();
    n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL release_early got %b want 1", key_held); end
    repeat (10) tick();
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL release_held got %b want 0", key_held); end
    n_cmp++; if (rows !== 4'b0001) begin n_fail++; $display("FAIL release_next_row got %b want 0001", rows); end
  endtask

  task automatic test_bounce();
    int kv0 = kv_cnt;
    bit got = 0;
    use_model = 1'b1;
    keys = '0;
    for (int i = 0; i < 8; i++) begin
      keys[0] = (i % 2 == 0);
      repeat (5) tick();
    end
    n_cmp++; if (kv_cnt != kv0) begin n_fail++; $display("FAIL bounce_pulses got %0d want 0", kv_cnt - kv0); end
    keys[0] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (kv_cnt != kv0) got = 1;
    end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL bounce_timeout got none want key_valid"); end
    repeat (3) tick();
    n_cmp++; if (kv_cnt - kv0 != 1) begin n_fail++; $display("FAIL bounce_count got %0d want 1", kv_cnt - kv0); end
    n_cmp++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL bounce_code got %0d want 0", key_code); end
    n_cmp++; if (rows !== 4'b1000) begin n_fail++; $display("FAIL bounce_rows got %b want 1000", rows); end
  endtask

  task automatic test_release_glitch();
    int kv0 = kv_cnt;
    int mp0 = mp_cnt;
    bit dropped = 0;
    bit got = 0;
    keys[0] = 1'b0;
    repeat (5) begin tick(); if (key_held !== 1'b1) dropped = 1; end
    keys[0] = 1'b1;
    repeat (20) begin tick(); if (key_held !== 1'b1) dropped = 1; end
    n_cmp++; if (dropped) begin n_fail++; $display("FAIL glitch_held got drop want steady 1"); end
    n_cmp++; if (kv_cnt != kv0) begin n_fail++; $display("FAIL glitch_pulses got %0d want 0", kv_cnt - kv0); end
    keys[1] = 1'b1;   // row 0 now reads 0011
    repeat (30) tick();
    n_cmp++; if (kv_cnt != kv0 || mp_cnt != mp0) begin
      n_fail++; $display("FAIL extra_key_pulses got kv %0d mp %0d want 0 0", kv_cnt - kv0, mp_cnt - mp0); end
    n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL extra_key_held got %b want 1", key_held); end
    keys = '0;
    for (int i = 0; i < 60 && !got; i++) begin tick(); if (key_held === 1'b0) got = 1; end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL glitch_release got held=%b want 0", key_held); end
  endtask

  task automatic test_multi_press();
    int kv0;
    int mp0;
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin tick(); if (rows === 4'b0100) got = 1; end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL wait_row1 got %b want 0100", rows); end
    kv0 = kv_cnt;
    mp0 = mp_cnt;
    keys[4] = 1'b1;
    keys[6] = 1'b1;   // row 1 reads 0101
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin tick(); if (mp_cnt != mp0) got = 1; end
    repeat (3) tick();
    n_cmp++; if (mp_cnt - mp0 != 1) begin n_fail++; $display("FAIL multi_count got %0d want 1", mp_cnt - mp0); end
    n_cmp++; if (kv_cnt != kv0) begin n_fail++; $display("FAIL multi_kv got %0d want 0", kv_cnt - kv0); end
    n_cmp++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL multi_code got %0d want 0", key_code); end
    n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL multi_held got %b want 1", key_held); end
    n_cmp++; if (rows !== 4'b0100) begin n_fail++; $display("FAIL multi_rows got %b want 0100", rows); end
    keys = '0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin tick(); if (key_held === 1'b0) got = 1; end
    n_cmp++; if (!got) begin n_fail++; $display("FAIL multi_release got held=%b want 0", key_held); end
    n_cmp++; if (both_cnt != 0) begin n_fail++; $display("FAIL kv_mp_overlap got %0d want 0", both_cnt); end
  endtask

  task automatic test_reset_in_held();
    int kv0 = kv_cnt;
    bit got = 0;
    keys[13] = 1'b1;   // row 3, column 1
    for (int i = 0; i < 200 && !got; i++) begin tick(); if (kv_cnt != kv0) got = 1; end
    n_cmp++; if (key_code !== 4'd13) begin n_fail++; $display("FAIL held_code got %0d want 13", key_code); end
    n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL held_pre_reset got %b want 1", key_held); end
    reset = 1'b0;
    tick();
    n_cmp++; if (rows !== 4'b1000) begin n_fail++; $display("FAIL midreset_rows got %b want 1000", rows); end
    n_cmp++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL midreset_code got %0d want 0", key_code); end
    n_cmp++; if ({key_valid, key_held, multi_press} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_flags got %b want 000", {key_valid, key_held, multi_press}); end
    keys = '0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (8) tick();
    n_cmp++; if (rows !== 4'b0100) begin n_fail++; $display("FAIL restart_rows got %b want 0100", rows); end
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL restart_held got %b want 0", key_held); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_release_glitch();
    test_multi_press();
    test_reset_in_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
